// File: rtl/dcache_lookup_unit_pkg.sv
// Shared geometry of the 8-line direct-mapped data cache and the address field helpers.
package dcache_lookup_unit_pkg;

    localparam int LINES   = 8;
    localparam int INDEX_W = 3;
    localparam int TAG_W   = 3;
    localparam int WORD_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int BLOCK_W = 4 * WORD_W;

    // Byte address layout: tag[7:5] | index[4:2] | offset[1:0]
    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[7:5];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[4:2];
    endfunction

    function automatic logic [1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[1:0];
    endfunction

endpackage

// File: rtl/dcache_lookup_unit_byte_select.sv
// 4:1 byte mux that picks one byte of a block by the address offset.
module dcache_lookup_unit_byte_select
    import dcache_lookup_unit_pkg::*;
(
    input  logic [BLOCK_W-1:0] block,
    input  logic [1:0]         offset,
    output logic [WORD_W-1:0]  byte_out
);

    always_comb begin
        byte_out = '0;
        case (offset)
            2'b00: byte_out = block[7:0];
            2'b01: byte_out = block[15:8];
            2'b10: byte_out = block[23:16];
            2'b11: byte_out = block[31:24];
            default: byte_out = '0;
        endcase
    end

endmodule

// File: rtl/dcache_lookup_unit_tag_compare.sv
// Equality comparator between the stored tag of the indexed line and the address tag.
module dcache_lookup_unit_tag_compare
    import dcache_lookup_unit_pkg::*;
(
    input  logic [TAG_W-1:0] stored_tag,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             match
);

    assign match = (stored_tag == lookup_tag);

endmodule

// File: rtl/dcache_lookup_unit.sv
// Data/tag/valid/dirty arrays of the direct-mapped cache with a purely combinational lookup path.
module dcache_lookup_unit
    import dcache_lookup_unit_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       write_en,
    input  logic [WORD_W-1:0]          writedata,
    input  logic                       fill_en,
    input  logic [BLOCK_W-1:0]         fill_data,
    input  logic                       clean_en,
    output logic                       hit,
    output logic                       valid,
    output logic                       dirty,
    output logic [WORD_W-1:0]          readdata,
    output logic [TAG_W+INDEX_W-1:0]   victim_addr,
    output logic [BLOCK_W-1:0]         victim_block
);

    // fill_en, write_en and clean_en are level strobes sampled on the rising edge;
    // there is no valid/ready handshake. Priority is fill > write (hit only) > clean.
    logic [BLOCK_W-1:0] data_mem  [LINES];
    logic [TAG_W-1:0]   tag_mem   [LINES];
    logic [LINES-1:0]   valid_mem;
    logic [LINES-1:0]   dirty_mem;

    logic [TAG_W-1:0]   lookup_tag;
    logic [INDEX_W-1:0] index;
    logic [1:0]         offset;
    logic               match;

    assign lookup_tag = addr_tag(address);
    assign index      = addr_index(address);
    assign offset     = addr_offset(address);

    dcache_lookup_unit_tag_compare u_tag_compare (
        .stored_tag (tag_mem[index]),
        .lookup_tag (lookup_tag),
        .match      (match)
    );

    dcache_lookup_unit_byte_select u_byte_select (
        .block    (data_mem[index]),
        .offset   (offset),
        .byte_out (readdata)
    );

    assign valid        = valid_mem[index];
    assign dirty        = dirty_mem[index];
    assign hit          = valid & match;
    assign victim_addr  = {tag_mem[index], index};
    assign victim_block = data_mem[index];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                data_mem[i] <= '0;
                tag_mem[i]  <= '0;
            end
            valid_mem <= '0;
            dirty_mem <= '0;
        end else if (fill_en) begin
            data_mem[index]  <= fill_data;
            tag_mem[index]   <= lookup_tag;
            valid_mem[index] <= 1'b1;
            dirty_mem[index] <= 1'b0;
        end else if (write_en && hit) begin
            // Only the addressed byte lane changes; tag and valid stay as they are.
            data_mem[index][{offset, 3'b000} +: WORD_W] <= writedata;
            dirty_mem[index] <= 1'b1;
        end else if (clean_en) begin
            dirty_mem[index] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_lookup_unit.sv
// Directed bench: stimulus pushes hand-computed lookups into a queue, a negedge monitor pops and checks.
module tb_dcache_lookup_unit;

    localparam int EXP_W = 1 + 1 + 1 + 8 + 6 + 32;

    logic        clock;
    logic        reset;
    logic [7:0]  address;
    logic        write_en;
    logic [7:0]  writedata;
    logic        fill_en;
    logic [31:0] fill_data;
    logic        clean_en;
    logic        hit;
    logic        valid;
    logic        dirty;
    logic [7:0]  readdata;
    logic [5:0]  victim_addr;
    logic [31:0] victim_block;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    logic             check_req;
    int               tests_run;
    int               tests_failed;

    dcache_lookup_unit dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .write_en     (write_en),
        .writedata    (writedata),
        .fill_en      (fill_en),
        .fill_data    (fill_data),
        .clean_en     (clean_en),
        .hit          (hit),
        .valid        (valid),
        .dirty        (dirty),
        .readdata     (readdata),
        .victim_addr  (victim_addr),
        .victim_block (victim_block)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // driver tasks
    task automatic strobe(input logic [7:0] a, input logic we, input logic [7:0] wd,
                          input logic fe, input logic [31:0] fd, input logic ce);
        @(posedge clock);
        #1;
        address   = a;
        write_en  = we;
        writedata = wd;
        fill_en   = fe;
        fill_data = fd;
        clean_en  = ce;
        @(posedge clock);
        #1;
        write_en = 1'b0;
        fill_en  = 1'b0;
        clean_en = 1'b0;
    endtask

    task automatic probe_now(input string name, input logic [7:0] a,
                             input logic e_hit, input logic e_valid, input logic e_dirty,
                             input logic [7:0] e_rd, input logic [5:0] e_va, input logic [31:0] e_vb);
        address = a;
        exp_q.push_back({e_hit, e_valid, e_dirty, e_rd, e_va, e_vb});
        name_q.push_back(name);
        check_req = 1'b1;
        @(negedge clock);
        #1;
        check_req = 1'b0;
    endtask

    task automatic probe(input string name, input logic [7:0] a,
                         input logic e_hit, input logic e_valid, input logic e_dirty,
                         input logic [7:0] e_rd, input logic [5:0] e_va, input logic [31:0] e_vb);
        @(posedge clock);
        #1;
        probe_now(name, a, e_hit, e_valid, e_dirty, e_rd, e_va, e_vb);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (check_req) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL monitor: output presented with no expected entry queued");
            end else begin
                logic [EXP_W-1:0] exp_v;
                logic [EXP_W-1:0] got_v;
                string            nm;
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                got_v = {hit, valid, dirty, readdata, victim_addr, victim_block};
                if (got_v !== exp_v) begin
                    tests_failed++;
                    $display("FAIL %s: got hit=%b valid=%b dirty=%b rd=%h va=%b vb=%h, exp hit=%b valid=%b dirty=%b rd=%h va=%b vb=%h",
                             nm, hit, valid, dirty, readdata, victim_addr, victim_block,
                             exp_v[48], exp_v[47], exp_v[46], exp_v[45:38], exp_v[37:32], exp_v[31:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        check_req    = 1'b0;
        reset        = 1'b1;
        address      = 8'h00;
        write_en     = 1'b0;
        writedata    = 8'h00;
        fill_en      = 1'b0;
        fill_data    = 32'h0;
        clean_en     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        probe("reset_state", 8'h00, 0, 0, 0, 8'h00, 6'b000000, 32'h0);

        strobe(8'h04, 0, 8'h00, 1, 32'hDDCCBBAA, 0);
        probe("fill_b0", 8'h04, 1, 1, 0, 8'hAA, 6'b000001, 32'hDDCCBBAA);
        probe("fill_b1", 8'h05, 1, 1, 0, 8'hBB, 6'b000001, 32'hDDCCBBAA);
        probe("fill_b2", 8'h06, 1, 1, 0, 8'hCC, 6'b000001, 32'hDDCCBBAA);
        probe("fill_b3", 8'h07, 1, 1, 0, 8'hDD, 6'b000001, 32'hDDCCBBAA);

        strobe(8'h06, 1, 8'h5A, 0, 32'h0, 0);
        probe("write_hit_byte", 8'h06, 1, 1, 1, 8'h5A, 6'b000001, 32'hDD5ABBAA);
        probe("write_hit_other", 8'h05, 1, 1, 1, 8'hBB, 6'b000001, 32'hDD5ABBAA);

        probe("conflict_miss", 8'h24, 0, 1, 1, 8'hAA, 6'b000001, 32'hDD5ABBAA);
        strobe(8'h24, 0, 8'h00, 0, 32'h0, 1);
        probe("clean", 8'h24, 0, 1, 0, 8'hAA, 6'b000001, 32'hDD5ABBAA);
        strobe(8'h24, 0, 8'h00, 1, 32'h11223344, 0);
        probe("evict_fill", 8'h24, 1, 1, 0, 8'h44, 6'b001001, 32'h11223344);
        probe("evicted_miss", 8'h04, 0, 1, 0, 8'h44, 6'b001001, 32'h11223344);

        strobe(8'h48, 1, 8'h77, 0, 32'h0, 0);
        probe("write_miss", 8'h48, 0, 0, 0, 8'h00, 6'b000010, 32'h0);

        strobe(8'h25, 1, 8'h99, 0, 32'h0, 1);
        probe("write_beats_clean", 8'h25, 1, 1, 1, 8'h99, 6'b001001, 32'h11229944);
        strobe(8'h25, 1, 8'h00, 1, 32'hAABBCCDD, 0);
        probe("fill_beats_write", 8'h25, 1, 1, 0, 8'hCC, 6'b001001, 32'hAABBCCDD);

        strobe(8'hFC, 0, 8'h00, 1, 32'h0F0E0D0C, 0);
        probe("last_line", 8'hFF, 1, 1, 0, 8'h0F, 6'b111111, 32'h0F0E0D0C);

        // asynchronous reset between edges, checked before the next rising edge
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        probe_now("async_reset", 8'h25, 0, 0, 0, 8'h00, 6'b000001, 32'h0);
        strobe(8'h25, 1, 8'h55, 1, 32'hFFFFFFFF, 0);
        probe("update_in_reset", 8'h25, 0, 0, 0, 8'h00, 6'b000001, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        probe("after_reset_line1", 8'h25, 0, 0, 0, 8'h00, 6'b000001, 32'h0);
        probe("after_reset_line7", 8'hFF, 0, 0, 0, 8'h00, 6'b000111, 32'h0);

        // bounded drain of the expected queue
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
            tests_failed += exp_q.size();
        end

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dcache_lookup_unit.md
Name: dcache_lookup_unit

Overview:
- Storage and lookup datapath of an 8-line direct-mapped data cache; 8-bit byte address, 32-bit (4-byte) blocks.
- Holds data, tag, valid and dirty arrays.
- Lookup path: equality tag comparator, hit generation and byte-select mux over the indexed block.
- Sits between the CPU-side port and the cache controller FSM. The FSM drives the fill/clean/write strobes and consumes the hit, dirty and victim outputs.

Parameters:
- LINES, 8, number of cache lines.
- INDEX_W, 3, index width; address[4:2].
- TAG_W, 3, tag width; address[7:5].
- WORD_W, 8, byte/word width; offset address[1:0].

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- address  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
- write_en  input  1  CPU write request; byte is stored only on a hit.
- writedata  input  8  byte to store on a write hit.
- fill_en  input  1  refill indexed line from memory.
- fill_data  input  32  refill block.
- clean_en  input  1  clear dirty bit of indexed line after writeback.
- hit  output  1  valid and tag match.
- valid  output  1  valid bit of indexed line.
- dirty  output  1  dirty bit of indexed line.
- readdata  output  8  selected byte of indexed block.
- victim_addr  output  6  {stored tag, index}; block address for writeback.
- victim_block  output  32  indexed block; writeback data.

Behaviour:
- Lookup is fully combinational from address and array contents; there is no registered output.
- Tag compare: match = (stored_tag == address[7:5]), all bits equal.
- hit = valid & match.
- Byte select:
  - offset 00 -> block[7:0]
  - offset 01 -> block[15:8]
  - offset 10 -> block[23:16]
  - offset 11 -> block[31:24]
- readdata is driven regardless of hit. Consumers must qualify it with hit.
- Write hit (posedge, write_en & hit, no fill_en):
  - Only the offset-selected byte of the indexed line is replaced; other bytes are unchanged.
  - dirty set to 1.
  - Tag and valid are unchanged.
- write_en on a miss has no effect on any array.
- Fill (posedge, fill_en):
  - Indexed line data = fill_data.
  - tag = address[7:5], valid = 1, dirty = 0.
- Clean (posedge, clean_en, no fill_en): dirty of the indexed line = 0.
- Simultaneous strobes:
  - Priority is fill > write > clean.
  - If write_en and clean_en are both asserted on a hit, the write wins and dirty ends at 1.
- Updates are visible on hit/readdata immediately after the clock edge, with no extra cycle.
- Reset (asynchronous, immediate, also mid-operation):
  - All valid = 0, dirty = 0, data = 0, tag = 0.
  - Resulting outputs: hit = 0, valid = 0, dirty = 0, readdata = 0, victim_block = 0, victim_addr = {000, index}.
- While reset is held, clocked updates are ignored.
- Index wrap: addresses 0x00 and 0x20 map to the same line (index 0) with different tags. Filling one evicts the other.

Decomposition:
- Shared package holds constants TAG_W, INDEX_W, WORD_W, LINES and the field-slice helpers (tag/index/offset positions).
- Two natural leaf sub-modules:
  - tag_compare: TAG_W equality comparator, 1-bit out.
  - byte_select: 4:1 WORD_W mux driven by offset.
- The top level holds the arrays and the write/fill/clean logic.

Test Plan:
1. Reset, then address 0x00 -> hit=0, valid=0, dirty=0, readdata=0x00.
2. fill_en with address 0x04, fill_data 0xDDCCBBAA -> after the edge, addresses 0x04..0x07 give hit=1 and readdata AA, BB, CC, DD respectively; dirty=0.
3. Write hit: write_en, address 0x06, writedata 0x5A on the filled line -> readdata@0x06=0x5A, @0x05=0xBB, dirty=1, victim_block=0xDD5ABBAA.
4. Conflict: address 0x24 (same index 1, tag 001) -> hit=0, dirty=1, victim_addr=0b000001. Then clean_en -> dirty=0. Then fill 0x11223344 -> hit=1, readdata@0x24=0x44, and address 0x04 now misses.
5. Write miss: write_en, address 0x48 to an invalid line -> no change, valid=0, dirty=0.
6. Assert reset asynchronously between edges after scenario 4 -> hit=0 and readdata=0 immediately; write_en with fill_en held during reset -> no update.
